// File: rtl/ad_capture_ctrl.sv
// Triggered capture controller: pre-trigger fill, level-crossing wait, post-trigger fill, hold until released.
// Optional auto-trigger timeout is built when AD_CAPTURE_AUTO_TRIG_EN is defined.
module ad_capture_ctrl #(
  parameter int          ADDR_W      = 10,
  parameter int          PRE_LEN     = 32,
  parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
  input  logic              adc_clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [7:0]        trig_level,
  input  logic              trig_falling,
  input  logic [7:0]        sample,
  input  logic              rd_ack,
  output logic              buf_wr,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              auto_trig
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(PRE_LEN - 1);
  localparam logic [ADDR_W-1:0] POST_END = ADDR_W'(DEPTH - PRE_LEN);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state, next_state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] cnt;
  logic [7:0]        prev;
  logic              crossing, timeout, hit, wr_en;

  assign crossing = trig_falling ? (prev >= trig_level && sample <  trig_level)
                                 : (prev <  trig_level && sample >= trig_level);
  assign hit      = crossing || timeout;

  // POST holds for one extra, write-free cycle once cnt reaches POST_END, so done/busy
  // switch on the cycle after the final write is presented.
  assign wr_en = (state == S_PRE) || (state == S_WAIT) ||
                 (state == S_POST && cnt != POST_END);

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    case (state)
      S_IDLE: if (arm) next_state = S_PRE;
      S_PRE:  if (cnt == PRE_LAST) next_state = S_WAIT;
      S_WAIT: if (hit) next_state = S_POST;
      S_POST: if (cnt == POST_END) next_state = S_DONE;
      S_DONE: begin
        if (arm)         next_state = S_PRE;
        else if (rd_ack) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      cnt       <= '0;
      prev      <= '0;
      buf_wr    <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      trig_addr <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      state  <= next_state;
      prev   <= sample;
      busy   <= (next_state == S_PRE) || (next_state == S_WAIT) || (next_state == S_POST);
      done   <= (next_state == S_DONE);
      buf_wr <= wr_en;
      if (wr_en) begin
        buf_addr <= wr_ptr;
        buf_data <= sample;
        wr_ptr   <= wr_ptr + ONE;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            wr_ptr <= '0;
            cnt    <= '0;
          end
        end
        S_PRE:  cnt <= (cnt == PRE_LAST) ? '0 : cnt + ONE;
        S_WAIT: begin
          // The trigger write itself is the first of the POST_END post-trigger writes.
          if (hit) begin
            trig_addr <= wr_ptr;
            cnt       <= ONE;
          end
        end
        S_POST: if (cnt != POST_END) cnt <= cnt + ONE;
        default: ;
      endcase
    end
  end

`ifdef AD_CAPTURE_AUTO_TRIG_EN
  logic [23:0] to_cnt;

  assign timeout = (state == S_WAIT) && (to_cnt == TIMEOUT_CYC - 24'd1);

  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      to_cnt    <= '0;
      auto_trig <= 1'b0;
    end else begin
      if (state != S_WAIT)
        to_cnt <= '0;
      else if (!hit)
        to_cnt <= to_cnt + 24'd1;
      if ((state == S_IDLE || state == S_DONE) && arm)
        auto_trig <= 1'b0;
      else if (state == S_WAIT && hit)
        auto_trig <= !crossing;
    end
  end
`else
  localparam logic [23:0] unused_timeout_cyc = TIMEOUT_CYC;

  assign timeout   = 1'b0;
  assign auto_trig = 1'b0;
`endif

endmodule
